// File: rtl/gpi_if.sv
// Peripheral bus between a CPU-side master and the gpi input block.
interface gpi_if #(
   parameter int NBIT = 4
);
   logic [3:0]      addr_in;
   logic [NBIT-1:0] gpi_din;
   logic            gpi_req;
   logic            gpi_we;
   logic [NBIT-1:0] gpi_dout;

   modport master (output addr_in, gpi_din, gpi_req, gpi_we, input gpi_dout);
   modport slave  (input addr_in, gpi_din, gpi_req, gpi_we, output gpi_dout);
endinterface

// File: rtl/gpi.sv
// General-purpose inputs: 2-flop sync, per-bit debounce, enabled edge detect into
// sticky W1C status, level interrupt and a registered read port.
module gpi #(
   parameter int NBIT      = 4,
   parameter int DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NBIT-1:0] gpi_pins,
   gpi_if.slave            bus,
   output logic            gpi_irq
);
   localparam int CW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;

   logic [NBIT-1:0] r_sync1;
   logic [NBIT-1:0] r_sync2;
   logic [NBIT-1:0] r_db;
   logic [NBIT-1:0] r_rise_en;
   logic [NBIT-1:0] r_fall_en;
   logic [NBIT-1:0] r_status;
   logic [NBIT-1:0] r_dout;

   logic [NBIT-1:0] w_db_next;
   logic [NBIT-1:0] w_rise;
   logic [NBIT-1:0] w_fall;
   logic [NBIT-1:0] w_w1c;
   logic [NBIT-1:0] w_rd_data;
   logic            w_wr;
   logic            w_rd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= gpi_pins;
         r_sync2 <= r_sync1;
      end
   end

   generate
      if (DB_CYCLES == 0) begin : g_nodb
         assign w_db_next = r_sync2;
      end else begin : g_db
         logic [CW-1:0] r_cnt [NBIT];

         // A bit qualifies when it has disagreed with DB for DB_CYCLES consecutive edges.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int i = 0; i < NBIT; i++) r_cnt[i] <= '0;
            end else begin
               for (int i = 0; i < NBIT; i++) begin
                  if (r_sync2[i] == r_db[i])
                     r_cnt[i] <= '0;
                  else if (r_cnt[i] == CW'(DB_CYCLES - 1))
                     r_cnt[i] <= '0;
                  else
                     r_cnt[i] <= r_cnt[i] + CW'(1);
               end
            end
         end

         always_comb begin
            w_db_next = r_db;
            for (int i = 0; i < NBIT; i++) begin
               if ((r_sync2[i] != r_db[i]) && (r_cnt[i] == CW'(DB_CYCLES - 1)))
                  w_db_next[i] = r_sync2[i];
            end
         end
      end
   endgenerate

   assign w_rise = w_db_next & ~r_db & r_rise_en;
   assign w_fall = ~w_db_next & r_db & r_fall_en;

   assign w_wr  = bus.gpi_req & bus.gpi_we;
   assign w_rd  = bus.gpi_req & ~bus.gpi_we;
   assign w_w1c = (w_wr && (bus.addr_in == 4'h3)) ? bus.gpi_din : '0;

   always_comb begin
      w_rd_data = '0;
      case (bus.addr_in)
         4'h0:    w_rd_data = r_db;
         4'h1:    w_rd_data = r_rise_en;
         4'h2:    w_rd_data = r_fall_en;
         4'h3:    w_rd_data = r_status;
         default: w_rd_data = '0;
      endcase
   end

   // New edges are OR-ed in after the W1C mask so a same-cycle set survives a clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_db      <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_status  <= '0;
         r_dout    <= '0;
      end else begin
         r_db     <= w_db_next;
         r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
         if (w_wr && (bus.addr_in == 4'h1)) r_rise_en <= bus.gpi_din;
         if (w_wr && (bus.addr_in == 4'h2)) r_fall_en <= bus.gpi_din;
         if (w_rd) r_dout <= w_rd_data;
      end
   end

   assign bus.gpi_dout = r_dout;
   assign gpi_irq      = |r_status;
endmodule

// File: tb/tb_gpi.sv
// Bench for gpi: directed latency/glitch/W1C/collision/reset cases plus random traffic,
// checked every cycle against a window-based reference model.
module tb_gpi;
   localparam int NBIT = 4;
   localparam int DBC  = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic [NBIT-1:0] pins;
   logic            irq;

   gpi_if #(.NBIT(NBIT)) bus ();

   gpi #(.NBIT(NBIT), .DB_CYCLES(DBC)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .gpi_pins (pins),
      .bus      (bus),
      .gpi_irq  (irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [NBIT-1:0] m_db, m_rise, m_fall, m_status, m_dout;
   logic [NBIT-1:0] samp[$];

   task automatic chk_val(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_db     = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_status = '0;
      m_dout   = '0;
      samp.delete();
   endtask

   // Synchronised pin value seen before the current edge, 'back' edges further in the past.
   function automatic logic [NBIT-1:0] s2_hist(int back);
      int idx;
      idx = samp.size() - 2 - back;
      if (idx >= 0) return samp[idx];
      return '0;
   endfunction

   function automatic logic [NBIT-1:0] reg_val(logic [3:0] a);
      case (a)
         4'h0:    return m_db;
         4'h1:    return m_rise;
         4'h2:    return m_fall;
         4'h3:    return m_status;
         default: return '0;
      endcase
   endfunction

   task automatic model_step(logic [NBIT-1:0] p, logic rq, logic w, logic [3:0] a,
                             logic [NBIT-1:0] d);
      logic [NBIT-1:0] nd, h, rise, fall, st;
      logic q;
      nd = m_db;
      for (int b = 0; b < NBIT; b++) begin
         if (DBC == 0) begin
            h = s2_hist(0);
            nd[b] = h[b];
         end else begin
            q = 1'b1;
            for (int k = 0; k < DBC; k++) begin
               h = s2_hist(k);
               if (h[b] == m_db[b]) q = 1'b0;
            end
            if (q) nd[b] = ~m_db[b];
         end
      end
      rise = nd & ~m_db & m_rise;
      fall = ~nd & m_db & m_fall;
      if (rq && !w) m_dout = reg_val(a);
      st = m_status;
      if (rq && w) begin
         case (a)
            4'h1:    m_rise = d;
            4'h2:    m_fall = d;
            4'h3:    st = st & ~d;
            default: ;
         endcase
      end
      m_status = st | rise | fall;
      m_db = nd;
      samp.push_back(p);
      if (samp.size() > 16) void'(samp.pop_front());
   endtask

   task automatic tick();
      logic [NBIT-1:0] p, d;
      logic [3:0] a;
      logic rq, w;
      p  = pins;
      d  = bus.gpi_din;
      a  = bus.addr_in;
      rq = bus.gpi_req;
      w  = bus.gpi_we;
      @(posedge clk);
      model_step(p, rq, w, a, d);
      #1;
      chk_val("dout", bus.gpi_dout, m_dout);
      chk_val("irq", irq, |m_status);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_wr(logic [3:0] a, logic [NBIT-1:0] d);
      bus.gpi_req = 1'b1;
      bus.gpi_we  = 1'b1;
      bus.addr_in = a;
      bus.gpi_din = d;
      tick();
      bus.gpi_req = 1'b0;
      bus.gpi_we  = 1'b0;
   endtask

   task automatic bus_rd(logic [3:0] a, output logic [NBIT-1:0] d);
      bus.gpi_req = 1'b1;
      bus.gpi_we  = 1'b0;
      bus.addr_in = a;
      tick();
      bus.gpi_req = 1'b0;
      d = bus.gpi_dout;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NBIT-1:0] rd;
      int lat;
      int idx;

      resetn      = 1'b0;
      pins        = '0;
      bus.gpi_req = 1'b0;
      bus.gpi_we  = 1'b0;
      bus.addr_in = '0;
      bus.gpi_din = '0;
      model_reset();
      #12 resetn = 1'b1;

      // 1: reset state over the whole address space
      for (int a = 0; a < 16; a++) begin
         bus_rd(4'(a), rd);
         chk_val("rst_read", rd, 0);
      end
      chk_val("rst_irq", irq, 0);

      // 2: rising-edge latency
      bus_wr(4'h1, 4'b0001);
      idle(10);
      pins[0] = 1'b1;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (irq) begin
            lat = i;
            break;
         end
      end
      chk_val("irq_latency", lat, 6);
      bus_rd(4'h0, rd);
      chk_val("data_after_rise", rd, 4'b0001);
      bus_rd(4'h3, rd);
      chk_val("status_after_rise", rd, 4'b0001);

      // 3: glitch filter, then a just-long-enough pulse
      bus_wr(4'h1, 4'b1111);
      bus_wr(4'h2, 4'b1111);
      bus_wr(4'h3, 4'b1111);
      pins[1] = 1'b1;
      idle(3);
      pins[1] = 1'b0;
      idle(10);
      bus_rd(4'h0, rd);
      chk_val("glitch_data", rd, 4'b0001);
      bus_rd(4'h3, rd);
      chk_val("glitch_status", rd, 4'b0000);
      chk_val("glitch_irq", irq, 0);
      pins[1] = 1'b1;
      idle(4);
      pins[1] = 1'b0;
      idle(3);
      bus_rd(4'h3, rd);
      chk_val("pulse_rise_status", rd, 4'b0010);
      idle(8);
      bus_rd(4'h3, rd);
      chk_val("pulse_fall_status", rd, 4'b0010);
      bus_rd(4'h0, rd);
      chk_val("pulse_fall_data", rd, 4'b0001);

      // 4: W1C
      pins[0] = 1'b0;
      idle(8);
      bus_rd(4'h3, rd);
      chk_val("w1c_pre", rd, 4'b0011);
      bus_wr(4'h3, 4'b0001);
      bus_rd(4'h3, rd);
      chk_val("w1c_one", rd, 4'b0010);
      chk_val("w1c_one_irq", irq, 1);
      bus_wr(4'h3, 4'b0010);
      chk_val("w1c_all_irq", irq, 0);
      bus_rd(4'h3, rd);
      chk_val("w1c_all", rd, 4'b0000);

      // 5: clear and new edge on the same bit in the same cycle
      pins[2] = 1'b1;
      idle(5);
      bus_wr(4'h3, 4'b0100);
      bus_rd(4'h3, rd);
      chk_val("collision", rd, 4'b0100);

      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            idx = int'($urandom_range(0, NBIT - 1));
            pins[idx] = ~pins[idx];
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.gpi_req = 1'b1;
            bus.gpi_we  = 1'($urandom_range(0, 1));
            bus.addr_in = 4'($urandom_range(0, 15));
            bus.gpi_din = NBIT'($urandom);
         end else begin
            bus.gpi_req = 1'b0;
         end
         tick();
      end
      bus.gpi_req = 1'b0;
      bus.gpi_we  = 1'b0;

      // 6: read-only and unmapped writes, then reset mid-debounce
      pins = '0;
      idle(10);
      bus_wr(4'h1, 4'b0101);
      bus_wr(4'h2, 4'b1010);
      bus_wr(4'h3, 4'b1111);
      bus_wr(4'h0, 4'b1111);
      bus_wr(4'h7, 4'b1111);
      bus_rd(4'h1, rd);
      chk_val("ro_rise_en", rd, 4'b0101);
      bus_rd(4'h2, rd);
      chk_val("ro_fall_en", rd, 4'b1010);
      bus_rd(4'h7, rd);
      chk_val("ro_unmapped", rd, 4'b0000);
      bus_rd(4'h0, rd);
      chk_val("ro_data", rd, 4'b0000);
      bus_rd(4'h3, rd);
      chk_val("ro_status", rd, 4'b0000);

      bus_wr(4'h1, 4'b1111);
      pins[3] = 1'b1;
      idle(8);
      bus_rd(4'h3, rd);
      chk_val("pre_rst_status", rd, 4'b1000);
      bus_rd(4'h1, rd);
      chk_val("pre_rst_dout", rd, 4'b1111);
      pins[0] = 1'b1;
      idle(3);
      #2 resetn = 1'b0;
      #1;
      chk_val("async_rst_dout", bus.gpi_dout, 0);
      chk_val("async_rst_irq", irq, 0);
      model_reset();
      #20 resetn = 1'b1;
      bus_wr(4'h1, 4'b1000);
      idle(10);
      bus_rd(4'h3, rd);
      chk_val("post_rst_status", rd, 4'b1000);
      bus_rd(4'h0, rd);
      chk_val("post_rst_data", rd, 4'b1001);
      chk_val("post_rst_irq", irq, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/gpi.md
Name: gpi

Overview:
- General-purpose input peripheral; the input-direction counterpart of the GPO block, on the same peripheral bus (addr_in / req / we / din / dout).
- Per bit, it synchronises each asynchronous input pin and debounces it.
- It detects rising and falling edges into a sticky, write-1-to-clear status register and drives a level interrupt.
- Software reads the debounced pin state and edge status through a registered read port.

Parameters:
- NBIT, 4: number of input pins and bus data width.
- DB_CYCLES, 4: consecutive stable cycles required before a debounced bit changes. 0 bypasses debounce.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- gpi_pins  input  NBIT  asynchronous external input pins.
- addr_in  input  4  register word address.
- gpi_din  input  NBIT  write data.
- gpi_req  input  1  bus request, single cycle.
- gpi_we  input  1  1 = write, 0 = read.
- gpi_dout  output  NBIT  registered read data.
- gpi_irq  output  1  interrupt, level, active-high.

Behaviour:
- Reset: asynchronous, on negedge resetn. The following all clear to 0:
  - sync flops, debounce counters, debounced value DB;
  - RISE_EN, FALL_EN, STATUS;
  - gpi_dout, gpi_irq.
- Synchroniser: two flops per bit. S2 is the second-stage output.
- Debounce, per bit, counter width clog2(DB_CYCLES+1):
  - If S2 == DB: counter <= 0.
  - Else if counter == DB_CYCLES-1: DB <= S2 and counter <= 0.
  - Else: counter + 1.
  - DB therefore updates on the DB_CYCLES-th consecutive edge with S2 != DB.
  - A glitch shorter than DB_CYCLES at S2 resets the counter and never reaches DB.
  - DB_CYCLES = 0: DB <= S2 every cycle, no counter logic.
- Edge detect, per bit, registered on the cycle DB updates:
  - rise = DB goes 0 to 1 and RISE_EN set.
  - fall = DB goes 1 to 0 and FALL_EN set.
  - The STATUS bit sets on the same edge that DB updates.
- Register map (word address):
  - 0x0 DATA: read-only, returns DB. Writes ignored.
  - 0x1 RISE_EN: read/write.
  - 0x2 FALL_EN: read/write.
  - 0x3 STATUS: read returns STATUS. Write is W1C: STATUS <= STATUS & ~gpi_din.
  - 0x4-0xF: read 0, writes ignored.
- Read:
  - gpi_req & ~gpi_we: gpi_dout <= selected register at the next edge, so data is valid in the cycle after the request.
  - gpi_dout holds its value when there is no read.
- Write:
  - gpi_req & gpi_we: target register updates at the next edge.
  - Write and read never occur in the same cycle (gpi_we selects one).
- Simultaneous W1C clear and new edge set on the same bit in the same cycle: set wins, bit stays 1.
- A read of STATUS returns the pre-update value; reads never clear STATUS.
- Clearing an enable bit does not clear an already-set STATUS bit.
- gpi_irq = |STATUS, combinational from the STATUS flops (no extra latency).
- Reset mid-debounce: counter and DB clear immediately. A pin held high then re-qualifies as a rising edge, reported only if RISE_EN is set again.
- Total latency, pin change to STATUS/irq: 2 sync edges + DB_CYCLES edges, i.e. STATUS visible after edge 2+DB_CYCLES.

Test Plan:
1. Reset, then read all addresses 0x0-0xF, one cycle each. Required: gpi_dout = 0 for every address, gpi_irq = 0.
2. DB_CYCLES=4, write RISE_EN=4'b0001. Drive pin0 0 to 1 synchronous to clk at edge E. Required:
   - DATA[0] and STATUS[0] become 1 exactly at edge E+6;
   - gpi_irq rises at E+6;
   - a read at 0x3 then returns 4'b0001.
3. Glitch filter: pulse pin1 high for 3 cycles with FALL_EN=RISE_EN=4'b1111. Required: DATA stays 0, STATUS stays 0, no irq. A 4-cycle-stable pulse then sets STATUS[1] (rise) and later STATUS[1] remains set after the fall.
4. W1C with STATUS=4'b0011: write 0x3 with 4'b0001. Required: STATUS = 4'b0010, gpi_irq stays 1. Write 4'b0010 → STATUS = 0, gpi_irq drops on the same edge.
5. Collision: arrange for the pin2 edge to qualify on the same edge as a W1C of bit 2. Required: STATUS[2] = 1 afterwards.
6. Write DATA (0x0) with 4'b1111 and write unmapped address 0x7. Required: no register changes. Assert resetn low mid-debounce → all outputs 0 asynchronously, before the next clk edge.
